// File: rtl/banked_mem_ctrl.sv
// banked_mem_ctrl: NUM_BANKS independent synchronous RAM banks sharing one
// write port and one registered read port. A per-bank clear engine zeroes
// a whole bank word-by-word with a busy/done handshake. err flags
// out-of-range bank selects and writes blocked by an active clear.
module banked_mem_ctrl #(
  parameter int NUM_BANKS = 4,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 10,
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr_start,
  input  logic [BANK_W-1:0] clr_bank,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;
  // Bank count widened by one bit so the range check also works when
  // NUM_BANKS is an exact power of two.
  localparam logic [BANK_W:0]   BANK_LIM = NUM_BANKS[BANK_W:0];
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem_q [NUM_BANKS][DEPTH];

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [BANK_W-1:0] cb_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  logic              wr_bank_ok_d;
  logic              rd_bank_ok_d;
  logic              clr_bank_ok_d;
  logic              clearing_d;
  logic              wr_blocked_d;
  logic              wr_go_d;
  logic              rd_zero_d;
  logic [BANK_W-1:0] rd_bank_idx_d;
  logic              err_d;

  // Decode bank legality, clear-engine collisions and the next err value.
  always_comb begin
    wr_bank_ok_d  = ({1'b0, wr_bank}  < BANK_LIM);
    rd_bank_ok_d  = ({1'b0, rd_bank}  < BANK_LIM);
    clr_bank_ok_d = ({1'b0, clr_bank} < BANK_LIM);
    clearing_d    = (state_q == ST_CLEAR);
    wr_blocked_d  = clearing_d && (wr_bank == cb_q);
    wr_go_d       = wr_en && wr_bank_ok_d && !wr_blocked_d;
    // A bank being cleared reads as zero even before the sweep reaches it.
    rd_zero_d     = !rd_bank_ok_d || (clearing_d && (rd_bank == cb_q));
    rd_bank_idx_d = rd_bank_ok_d ? rd_bank : '0;
    err_d         = (wr_en && (!wr_bank_ok_d || wr_blocked_d))
                 || (rd_en && !rd_bank_ok_d)
                 || (clr_start && (state_q == ST_IDLE) && !clr_bank_ok_d);
  end

  // RAM array: user writes plus clear-engine zeroing (never the same bank).
  always_ff @(posedge clk) begin
    if (wr_go_d) begin
      mem_q[wr_bank][wr_addr] <= wr_data;
    end
    if (!rst && clearing_d) begin
      mem_q[cb_q][ptr_q] <= '0;
    end
  end

  // Registered read port, read-first against a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (rd_en) begin
      rd_valid_q <= 1'b1;
      rd_data_q  <= rd_zero_d ? '0 : mem_q[rd_bank_idx_d][rd_addr];
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  // Clear FSM with registered busy/done and the single-cycle err pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cb_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (clr_start && clr_bank_ok_d) begin
            cb_q    <= clr_bank;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          // Pointer naturally wraps to zero on the last word.
          ptr_q <= ptr_q + ADDR_W'(1);
          if (ptr_q == PTR_LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ptr_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign clr_busy = busy_q;
  assign clr_done = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_banked_mem_ctrl.sv
// Directed bench for banked_mem_ctrl: a table of single-cycle read/write
// vectors followed by hand-written clear-engine sequences.
module tb_banked_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_bank;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [1:0] rd_bank;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       clr_start;
  logic [1:0] clr_bank;
  logic       clr_busy;
  logic       clr_done;
  logic       err;

  int checks = 0;
  int errors = 0;

  banked_mem_ctrl #(.NUM_BANKS(4), .DATA_W(8), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_start(clr_start), .clr_bank(clr_bank),
    .clr_busy(clr_busy), .clr_done(clr_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [1:0] wb;
    logic [9:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [1:0] rb;
    logic [9:0] ra;
    logic [7:0] exp_d;
    logic       exp_v;
    logic       exp_err;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic we, input logic [1:0] wb,
                              input logic [9:0] wa, input logic [7:0] wd,
                              input logic re, input logic [1:0] rb,
                              input logic [9:0] ra, input logic [7:0] exp_d,
                              input logic exp_v, input logic exp_err);
    vec_t v;
    v.we = we; v.wb = wb; v.wa = wa; v.wd = wd;
    v.re = re; v.rb = rb; v.ra = ra;
    v.exp_d = exp_d; v.exp_v = exp_v; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_bank = 2'd0; wr_addr = 10'd0; wr_data = 8'd0;
    rd_en = 1'b0; rd_bank = 2'd0; rd_addr = 10'd0;
    clr_start = 1'b0; clr_bank = 2'd0;
  endtask

  task automatic do_write(input logic [1:0] b, input logic [9:0] a, input logic [7:0] d);
    idle_inputs();
    wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d;
    tick();
    idle_inputs();
  endtask

  task automatic do_read(input string name, input logic [1:0] b, input logic [9:0] a,
                         input logic [7:0] exp);
    idle_inputs();
    rd_en = 1'b1; rd_bank = b; rd_addr = a;
    tick();
    idle_inputs();
    check({name, "_data"}, rd_data, exp);
    check({name, "_valid"}, rd_valid, 1);
  endtask

  task automatic start_clear(input logic [1:0] b);
    idle_inputs();
    clr_start = 1'b1; clr_bank = b;
    tick();
    idle_inputs();
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    bit seen;

    vecs[0]  = mk(1'b1, 2'd0, 10'd0,  8'd21,  1'b0, 2'd0, 10'd0,  8'd0,   1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 2'd0, 10'd2,  8'd30,  1'b0, 2'd0, 10'd0,  8'd0,   1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 2'd0, 10'd15, 8'd8,   1'b0, 2'd0, 10'd0,  8'd0,   1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 2'd0, 10'd0,  8'd0,   1'b1, 2'd0, 10'd0,  8'd21,  1'b1, 1'b0);
    vecs[4]  = mk(1'b0, 2'd0, 10'd0,  8'd0,   1'b1, 2'd0, 10'd2,  8'd30,  1'b1, 1'b0);
    vecs[5]  = mk(1'b0, 2'd0, 10'd0,  8'd0,   1'b1, 2'd0, 10'd15, 8'd8,   1'b1, 1'b0);
    vecs[6]  = mk(1'b0, 2'd0, 10'd0,  8'd0,   1'b0, 2'd0, 10'd0,  8'd8,   1'b0, 1'b0);
    vecs[7]  = mk(1'b1, 2'd3, 10'd0,  8'd21,  1'b0, 2'd0, 10'd0,  8'd8,   1'b0, 1'b0);
    vecs[8]  = mk(1'b1, 2'd3, 10'd1,  8'd1,   1'b0, 2'd0, 10'd0,  8'd8,   1'b0, 1'b0);
    vecs[9]  = mk(1'b1, 2'd3, 10'd2,  8'd18,  1'b0, 2'd0, 10'd0,  8'd8,   1'b0, 1'b0);
    vecs[10] = mk(1'b1, 2'd3, 10'd3,  8'd100, 1'b0, 2'd0, 10'd0,  8'd8,   1'b0, 1'b0);
    vecs[11] = mk(1'b0, 2'd0, 10'd0,  8'd0,   1'b1, 2'd0, 10'd0,  8'd21,  1'b1, 1'b0);
    vecs[12] = mk(1'b0, 2'd0, 10'd0,  8'd0,   1'b1, 2'd3, 10'd3,  8'd100, 1'b1, 1'b0);
    vecs[13] = mk(1'b1, 2'd1, 10'd5,  8'd7,   1'b0, 2'd0, 10'd0,  8'd100, 1'b0, 1'b0);
    vecs[14] = mk(1'b1, 2'd1, 10'd5,  8'd9,   1'b1, 2'd1, 10'd5,  8'd7,   1'b1, 1'b0);
    vecs[15] = mk(1'b0, 2'd0, 10'd0,  8'd0,   1'b1, 2'd1, 10'd5,  8'd9,   1'b1, 1'b0);
    vecs[16] = mk(1'b0, 2'd0, 10'd0,  8'd0,   1'b1, 2'd3, 10'd2,  8'd18,  1'b1, 1'b0);
    vecs[17] = mk(1'b0, 2'd0, 10'd0,  8'd0,   1'b0, 2'd0, 10'd0,  8'd18,  1'b0, 1'b0);

    // Reset state
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_busy", clr_busy, 0);
    check("rst_done", clr_done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    // Table-driven write/read vectors
    for (int i = 0; i < 18; i++) begin
      wr_en = vecs[i].we; wr_bank = vecs[i].wb; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_en = vecs[i].re; rd_bank = vecs[i].rb; rd_addr = vecs[i].ra;
      clr_start = 1'b0; clr_bank = 2'd0;
      tick();
      check($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_d);
      check($sformatf("vec%0d_valid", i), rd_valid, vecs[i].exp_v);
      check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
    end
    idle_inputs();

    // Full clear of bank 3
    start_clear(2'd3);
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 1100; c++) begin
      if (clr_busy) busy_cnt++;
      if (clr_done) begin
        done_cnt++;
        check("clr3_done_busy_low", clr_busy, 0);
      end
      tick();
    end
    check("clr3_busy_cycles", busy_cnt, 1024);
    check("clr3_done_pulses", done_cnt, 1);
    do_read("clr3_b3a3", 2'd3, 10'd3, 8'd0);
    do_read("clr3_b3a1023", 2'd3, 10'd1023, 8'd0);
    do_read("clr3_b0a2", 2'd0, 10'd2, 8'd30);

    // Clear of bank 2 with concurrent user traffic
    start_clear(2'd2);
    check("clr2_busy", clr_busy, 1);
    check("clr2_start_err", err, 0);
    do_write(2'd2, 10'd4, 8'd123);
    check("clr2_blocked_err", err, 1);
    tick();
    check("clr2_err_single", err, 0);
    wr_en = 1'b1; wr_bank = 2'd1; wr_addr = 10'd4; wr_data = 8'd55;
    clr_start = 1'b1; clr_bank = 2'd0;
    tick();
    idle_inputs();
    check("clr2_other_wr_err", err, 0);
    do_read("clr2_rd_cb", 2'd2, 10'd5, 8'd0);
    do_read("clr2_rd_b1a4", 2'd1, 10'd4, 8'd55);
    seen = 1'b0;
    for (int c = 0; c < 1100 && !seen; c++) begin
      tick();
      if (clr_done) seen = 1'b1;
    end
    check("clr2_done_seen", seen, 1);
    tick();
    check("clr2_done_single", clr_done, 0);
    do_read("clr2_ignored_start_b0", 2'd0, 10'd0, 8'd21);
    do_read("clr2_b2a4", 2'd2, 10'd4, 8'd0);

    // Reset in the middle of a clear of bank 2
    do_write(2'd2, 10'd50, 8'd77);
    do_write(2'd2, 10'd900, 8'd88);
    do_read("pre6_b2a50", 2'd2, 10'd50, 8'd77);
    start_clear(2'd2);
    for (int c = 0; c < 100; c++) tick();
    check("mid_clr_busy", clr_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", clr_busy, 0);
    check("abort_done", clr_done, 0);
    check("abort_rd_valid", rd_valid, 0);
    check("abort_rd_data", rd_data, 0);
    done_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < 1100; c++) begin
      if (clr_done) done_cnt++;
      if (clr_busy) busy_cnt++;
      tick();
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_no_busy", busy_cnt, 0);
    do_read("abort_b2a50", 2'd2, 10'd50, 8'd0);
    do_read("abort_b2a900", 2'd2, 10'd900, 8'd88);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
